// File: rtl/sync_sp_ram_be_clr.sv
// rtl/sync_sp_ram_be_clr.sv - single-port byte-enable RAM with handshake, output pipeline and clear engine
//
// Purpose: synchronous single-port RAM of DATA_DEPTH words of DATA_WIDTH bits
// with byte-granular writes, a request/grant handshake, 0..2 extra output
// register stages and a sweep engine that zero-fills the array.
//
// Ports:
//   Clk_CI      clock
//   Rst_RBI     synchronous active-low reset (array contents are kept)
//   Req_SI      access request
//   Gnt_SO      access accepted this cycle (combinational)
//   WrEn_SI     1 = write, 0 = read
//   BEn_SI      byte enables, bit i covers bits [8i+7:8i]
//   WrData_DI   write data
//   Addr_DI     word address
//   RdData_DO   read data, meaningful only while RdValid_SO is high
//   RdValid_SO  one-cycle pulse per granted read
//   Clr_SI      pulse that starts a clear sweep
//   Busy_SO     clear sweep in progress
module sync_sp_ram_be_clr #(
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned DATA_DEPTH     = 1024,
   parameter int unsigned OUT_REGS       = 0,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic                      Clk_CI,
   input  logic                      Rst_RBI,
   input  logic                      Req_SI,
   output logic                      Gnt_SO,
   input  logic                      WrEn_SI,
   input  logic [DATA_WIDTH/8-1:0]   BEn_SI,
   input  logic [DATA_WIDTH-1:0]     WrData_DI,
   input  logic [ADDR_WIDTH-1:0]     Addr_DI,
   output logic [DATA_WIDTH-1:0]     RdData_DO,
   output logic                      RdValid_SO,
   input  logic                      Clr_SI,
   output logic                      Busy_SO
);

   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
   // Stage 0 is the array output register; OUT_REGS stages follow it.
   localparam int unsigned NUM_STG   = OUT_REGS + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_chk_dw
      $error("sync_sp_ram_be_clr: DATA_WIDTH must be a multiple of 8 and at least 8");
   end
   if (DATA_DEPTH > (2 ** ADDR_WIDTH)) begin : g_chk_depth
      $error("sync_sp_ram_be_clr: DATA_DEPTH exceeds address space");
   end
   if (OUT_REGS > 2) begin : g_chk_oregs
      $error("sync_sp_ram_be_clr: OUT_REGS must be 0, 1 or 2");
   end

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   state_t                  state_SP;
   logic [ADDR_WIDTH-1:0]   clr_cnt_DP;

   logic                    gnt_S;
   logic                    rd_gnt_S;
   logic                    in_range_S;
   logic                    mem_we_S;
   logic [ADDR_WIDTH-1:0]   mem_addr_D;
   logic [DATA_WIDTH-1:0]   mem_wdata_D;
   logic [NUM_BYTES-1:0]    mem_be_S;

   logic [DATA_WIDTH-1:0]   mem_D [DATA_DEPTH];

   logic [DATA_WIDTH-1:0]   pipe_data_DP [NUM_STG];
   logic [NUM_STG-1:0]      pipe_vld_SP;

   assign gnt_S      = Req_SI & (state_SP == IDLE);
   assign rd_gnt_S   = gnt_S & ~WrEn_SI;
   assign in_range_S = (32'(Addr_DI) < DATA_DEPTH);

   // The sweep owns the write port while CLEAR; nothing touches the array
   // while reset is asserted so partially cleared contents survive it.
   always_comb begin
      mem_we_S    = 1'b0;
      mem_addr_D  = Addr_DI;
      mem_wdata_D = WrData_DI;
      mem_be_S    = BEn_SI;
      if (state_SP == CLEAR) begin
         mem_we_S    = Rst_RBI;
         mem_addr_D  = clr_cnt_DP;
         mem_wdata_D = '0;
         mem_be_S    = '1;
      end else if (gnt_S & WrEn_SI & in_range_S) begin
         mem_we_S    = Rst_RBI;
      end
   end

   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         state_SP   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         clr_cnt_DP <= '0;
      end else begin
         case (state_SP)
            IDLE: begin
               if (Clr_SI) begin
                  state_SP   <= CLEAR;
                  clr_cnt_DP <= '0;
               end
            end
            CLEAR: begin
               clr_cnt_DP <= clr_cnt_DP + 1'b1;
               if (clr_cnt_DP == LAST_ADDR) begin
                  state_SP   <= IDLE;
                  clr_cnt_DP <= '0;
               end
            end
            default: begin
               state_SP   <= IDLE;
               clr_cnt_DP <= '0;
            end
         endcase
      end
   end

   // Array itself has no reset so it maps onto block RAM.
   always_ff @(posedge Clk_CI) begin
      if (mem_we_S) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (mem_be_S[i]) begin
               mem_D[mem_addr_D][8*i +: 8] <= mem_wdata_D[8*i +: 8];
            end
         end
      end
   end

   // Data stages only load on a valid so RdData_DO holds between reads.
   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         pipe_vld_SP <= '0;
         for (int k = 0; k < NUM_STG; k++) begin
            pipe_data_DP[k] <= '0;
         end
      end else begin
         pipe_vld_SP[0] <= rd_gnt_S;
         if (rd_gnt_S) begin
            pipe_data_DP[0] <= in_range_S ? mem_D[Addr_DI] : '0;
         end
         for (int k = 1; k < NUM_STG; k++) begin
            pipe_vld_SP[k] <= pipe_vld_SP[k-1];
            if (pipe_vld_SP[k-1]) begin
               pipe_data_DP[k] <= pipe_data_DP[k-1];
            end
         end
      end
   end

   assign Gnt_SO     = gnt_S;
   assign Busy_SO    = (state_SP == CLEAR);
   assign RdData_DO  = pipe_data_DP[NUM_STG-1];
   assign RdValid_SO = pipe_vld_SP[NUM_STG-1];

endmodule

// File: tb/tb_sync_sp_ram_be_clr.sv
// tb/tb_sync_sp_ram_be_clr.sv - directed self-checking bench for sync_sp_ram_be_clr
module tb_sync_sp_ram_be_clr;

   logic        clk;
   logic        rstn;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wd;
   logic [3:0]  addr;
   logic        clr;

   logic        gnt0, gnt1, gnt2, gnt3;
   logic [31:0] rd0, rd1, rd2, rd3;
   logic        rv0, rv1, rv2, rv3;
   logic        busy0, busy1, busy2, busy3;

   int n_vec = 0;
   int n_err = 0;

   sync_sp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DATA_DEPTH(16), .OUT_REGS(0), .CLEAR_ON_RESET(1)) u0 (
      .Clk_CI(clk), .Rst_RBI(rstn), .Req_SI(req), .Gnt_SO(gnt0), .WrEn_SI(we), .BEn_SI(be),
      .WrData_DI(wd), .Addr_DI(addr), .RdData_DO(rd0), .RdValid_SO(rv0), .Clr_SI(clr), .Busy_SO(busy0));

   sync_sp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DATA_DEPTH(16), .OUT_REGS(1), .CLEAR_ON_RESET(1)) u1 (
      .Clk_CI(clk), .Rst_RBI(rstn), .Req_SI(req), .Gnt_SO(gnt1), .WrEn_SI(we), .BEn_SI(be),
      .WrData_DI(wd), .Addr_DI(addr), .RdData_DO(rd1), .RdValid_SO(rv1), .Clr_SI(clr), .Busy_SO(busy1));

   sync_sp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DATA_DEPTH(16), .OUT_REGS(2), .CLEAR_ON_RESET(1)) u2 (
      .Clk_CI(clk), .Rst_RBI(rstn), .Req_SI(req), .Gnt_SO(gnt2), .WrEn_SI(we), .BEn_SI(be),
      .WrData_DI(wd), .Addr_DI(addr), .RdData_DO(rd2), .RdValid_SO(rv2), .Clr_SI(clr), .Busy_SO(busy2));

   sync_sp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DATA_DEPTH(12), .OUT_REGS(0), .CLEAR_ON_RESET(1)) u3 (
      .Clk_CI(clk), .Rst_RBI(rstn), .Req_SI(req), .Gnt_SO(gnt3), .WrEn_SI(we), .BEn_SI(be),
      .WrData_DI(wd), .Addr_DI(addr), .RdData_DO(rd3), .RdValid_SO(rv3), .Clr_SI(clr), .Busy_SO(busy3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Checks 16 busy cycles from the current negedge with no read results.
   task automatic sweep16(input string tag);
      for (int i = 0; i < 16; i++) begin
         chk({tag, "_busy0"}, 32'(busy0), 32'd1);
         chk({tag, "_busy2"}, 32'(busy2), 32'd1);
         chk({tag, "_busy3"}, 32'(busy3), (i < 12) ? 32'd1 : 32'd0);
         chk({tag, "_gnt0"}, 32'(gnt0), 32'd0);
         tick();
      end
      chk({tag, "_busy0_end"}, 32'(busy0), 32'd0);
   endtask

   initial begin
      rstn = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; wd = '0; addr = '0; clr = 1'b0;
      tick();
      tick();
      chk("rst_rv0", 32'(rv0), 32'd0);
      chk("rst_rd0", rd0, 32'd0);
      chk("rst_rv2", 32'(rv2), 32'd0);
      chk("rst_busy0", 32'(busy0), 32'd1);

      // Power-up sweep: busy 16 cycles, request held but never granted.
      rstn = 1'b1; req = 1'b1; we = 1'b0; addr = 4'd0;
      #1;
      for (int i = 0; i < 16; i++) begin
         chk("init_busy0", 32'(busy0), 32'd1);
         chk("init_gnt0", 32'(gnt0), 32'd0);
         chk("init_busy3", 32'(busy3), (i < 12) ? 32'd1 : 32'd0);
         tick();
      end
      chk("init_busy0_end", 32'(busy0), 32'd0);
      chk("init_gnt0_end", 32'(gnt0), 32'd1);
      for (int a = 0; a < 16; a++) begin
         tick();
         chk("init_rv0", 32'(rv0), 32'd1);
         chk("init_rd0", rd0, 32'd0);
         if (a < 15) addr = 4'(a + 1);
         else req = 1'b0;
      end
      tick();
      chk("init_rv0_end", 32'(rv0), 32'd0);

      // Byte-enable merge and read latency per OUT_REGS.
      req = 1'b1; we = 1'b1; addr = 4'd3; wd = 32'hDEADBEEF; be = 4'hF;
      #1 chk("wr1_gnt0", 32'(gnt0), 32'd1);
      tick();
      wd = 32'h11223344; be = 4'b0101;
      tick();
      chk("wr_no_rv0", 32'(rv0), 32'd0);
      we = 1'b0;
      #1 chk("rd3_gnt0", 32'(gnt0), 32'd1);
      tick();
      req = 1'b0;
      chk("lat_rv0_t1", 32'(rv0), 32'd1);
      chk("lat_rd0_t1", rd0, 32'hDE22BE44);
      chk("lat_rv1_t1", 32'(rv1), 32'd0);
      chk("lat_rv2_t1", 32'(rv2), 32'd0);
      tick();
      chk("lat_rv0_t2", 32'(rv0), 32'd0);
      chk("lat_rd0_hold", rd0, 32'hDE22BE44);
      chk("lat_rv1_t2", 32'(rv1), 32'd1);
      chk("lat_rd1_t2", rd1, 32'hDE22BE44);
      chk("lat_rv2_t2", 32'(rv2), 32'd0);
      tick();
      chk("lat_rv1_t3", 32'(rv1), 32'd0);
      chk("lat_rv2_t3", 32'(rv2), 32'd1);
      chk("lat_rd2_t3", rd2, 32'hDE22BE44);
      tick();
      chk("lat_rv2_t4", 32'(rv2), 32'd0);

      // All-zero byte enables leave the word alone.
      req = 1'b1; we = 1'b1; addr = 4'd3; wd = 32'hFFFFFFFF; be = 4'h0;
      tick();
      we = 1'b0;
      tick();
      req = 1'b0;
      chk("be0_rv0", 32'(rv0), 32'd1);
      chk("be0_rd0", rd0, 32'hDE22BE44);

      // Back-to-back reads return in order, one per cycle.
      be = 4'hF; we = 1'b1; req = 1'b1;
      for (int a = 1; a <= 3; a++) begin
         addr = 4'(a); wd = 32'(9 + a);
         tick();
      end
      we = 1'b0; addr = 4'd1;
      for (int t = 0; t < 6; t++) begin
         tick();
         chk("b2b_rv0", 32'(rv0), (t < 3) ? 32'd1 : 32'd0);
         if (t < 3) chk("b2b_rd0", rd0, 32'(32'hA + t));
         chk("b2b_rv2", 32'(rv2), (t >= 2 && t < 5) ? 32'd1 : 32'd0);
         if (t >= 2 && t < 5) chk("b2b_rd2", rd2, 32'(32'hA + t - 2));
         if (t < 2) addr = 4'(t + 2);
         else req = 1'b0;
      end

      // Clear pulse alongside a granted write; a second pulse mid-sweep is ignored.
      req = 1'b1; we = 1'b1; addr = 4'd7; wd = 32'h5; be = 4'hF; clr = 1'b1;
      #1 chk("clrwr_gnt0", 32'(gnt0), 32'd1);
      tick();
      clr = 1'b0; we = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("clr_busy0", 32'(busy0), 32'd1);
         chk("clr_gnt0", 32'(gnt0), 32'd0);
         clr = (i == 8);
         tick();
      end
      clr = 1'b0;
      chk("clr_busy0_end", 32'(busy0), 32'd0);
      chk("clr_gnt0_end", 32'(gnt0), 32'd1);
      tick();
      req = 1'b0;
      chk("clr_rv0", 32'(rv0), 32'd1);
      chk("clr_rd0", rd0, 32'd0);
      tick();

      // Reset with a read in flight discards it and clears the data register.
      req = 1'b1; we = 1'b1; addr = 4'd3; wd = 32'h77; be = 4'hF;
      tick();
      we = 1'b0;
      tick();
      req = 1'b0; rstn = 1'b0;
      chk("fl_rv0", 32'(rv0), 32'd1);
      chk("fl_rd0", rd0, 32'h77);
      tick();
      rstn = 1'b1;
      chk("fl_rst_rd0", rd0, 32'd0);
      chk("fl_rst_rv0", 32'(rv0), 32'd0);
      for (int i = 0; i < 16; i++) begin
         chk("fl_rv1", 32'(rv1), 32'd0);
         chk("fl_rv2", 32'(rv2), 32'd0);
         chk("fl_busy0", 32'(busy0), 32'd1);
         tick();
      end
      chk("fl_busy0_end", 32'(busy0), 32'd0);

      // Reset at sweep cycle 8 restarts a full 16-cycle sweep.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("mid_busy0", 32'(busy0), 32'd1);
      rstn = 1'b0; req = 1'b1; we = 1'b0; addr = 4'd3;
      tick();
      rstn = 1'b1; req = 1'b0;
      sweep16("mid");
      chk("mid_rv0", 32'(rv0), 32'd0);

      // Out-of-range write dropped; read granted and returns zero.
      req = 1'b1; we = 1'b1; addr = 4'd13; wd = 32'h0000FFFF; be = 4'hF;
      #1 chk("oor_wr_gnt3", 32'(gnt3), 32'd1);
      tick();
      we = 1'b0;
      #1 chk("oor_rd_gnt3", 32'(gnt3), 32'd1);
      tick();
      chk("oor_rv3", 32'(rv3), 32'd1);
      chk("oor_rd3", rd3, 32'd0);
      chk("oor_rd0", rd0, 32'h0000FFFF);
      addr = 4'd0;
      for (int a = 0; a < 12; a++) begin
         tick();
         chk("oor_scan_rv3", 32'(rv3), 32'd1);
         chk("oor_scan_rd3", rd3, 32'd0);
         if (a < 11) addr = 4'(a + 1);
         else req = 1'b0;
      end
      tick();
      chk("oor_rv3_end", 32'(rv3), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
